// File: rtl/lsu_pkg.sv
// Shared state/size encodings and defaults for the LSU bus master.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10,
        ERR  = 2'b11
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_X = 2'b11
    } lsu_size_e;

    localparam int unsigned ACK_TIMEOUT_DEF = 15;

endpackage

// File: rtl/lsu_bus_master_lane_align.sv
// Combinational lane steering: byte enables, store replication, load
// extraction/extension and misalignment/illegal-size detection.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        load_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_fmt,
    output logic        misalign
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = rdata[{off, 3'b000} +: 8];
    assign lane_h = rdata[{off[1], 4'b0000} +: 16];

    always_comb begin
        be        = '0;
        wdata_rep = wdata;
        rdata_fmt = rdata;
        misalign  = 1'b0;
        case (lsu_size_e'(size))
            SZ_B: begin
                be        = 4'b0001 << off;
                wdata_rep = {4{wdata[7:0]}};
                rdata_fmt = {{24{~load_unsigned & lane_b[7]}}, lane_b};
            end
            SZ_H: begin
                be        = 4'b0011 << {off[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                rdata_fmt = {{16{~load_unsigned & lane_h[15]}}, lane_h};
                misalign  = off[0];
            end
            SZ_W: begin
                be       = '1;
                misalign = |off;
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/lsu_bus_master.sv
// Load/store unit bus master: req/ack handshake FSM with core stall.
// Optional REQ timeout enabled by defining LSU_TIMEOUT_EN.
module lsu_bus_master
    import lsu_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_valid,
    input  logic        lsu_we,
    input  logic [1:0]  lsu_size,
    input  logic        lsu_unsigned,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        stall,
    output logic [31:0] lsu_rdata,
    output logic        lsu_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    lsu_state_e  state;
    logic [3:0]  be;
    logic [31:0] wdata_rep;
    logic [31:0] rdata_fmt;
    logic        misalign;
    logic        timeout_hit;

    lsu_lane_align u_align (
        .size          (lsu_size),
        .off           (lsu_addr[1:0]),
        .load_unsigned (lsu_unsigned),
        .wdata         (lsu_wdata),
        .rdata         (bus_rdata),
        .be            (be),
        .wdata_rep     (wdata_rep),
        .rdata_fmt     (rdata_fmt),
        .misalign      (misalign)
    );

    assign stall = ((state == IDLE) && lsu_valid) || (state == REQ);

`ifdef LSU_TIMEOUT_EN
    logic [7:0] ack_cnt;

    // REQ is only ever entered from IDLE, so clearing in IDLE clears on entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_cnt <= '0;
        end else if (state == IDLE) begin
            ack_cnt <= '0;
        end else if ((state == REQ) && !bus_ack) begin
            ack_cnt <= ack_cnt + 8'd1;
        end
    end

    assign timeout_hit = (ack_cnt == 8'(ACK_TIMEOUT - 1));
`else
    assign timeout_hit = (ACK_TIMEOUT == 0) && 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            lsu_rdata <= '0;
            lsu_err   <= 1'b0;
        end else begin
            lsu_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (lsu_valid) begin
                        if (misalign) begin
                            state   <= ERR;
                            lsu_err <= 1'b1;
                        end else begin
                            state     <= REQ;
                            bus_req   <= 1'b1;
                            bus_we    <= lsu_we;
                            bus_addr  <= {lsu_addr[31:2], 2'b00};
                            bus_be    <= be;
                            bus_wdata <= wdata_rep;
                        end
                    end
                end
                REQ: begin
                    // An ack in the same cycle as the timeout limit takes priority.
                    if (bus_ack) begin
                        state   <= DONE;
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        if (!bus_we) begin
                            lsu_rdata <= rdata_fmt;
                        end
                    end else if (timeout_hit) begin
                        state   <= ERR;
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        lsu_err <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/lsu_bus_master.md
# lsu_bus_master

Load/store unit that turns the core's single-cycle data-memory access (MemWE, ALU address, rs2 data) into a multi-cycle request/acknowledge bus transaction toward an external data-memory responder. It sits between the EX/MEM boundary and the memory, and stalls the core until the access completes. It handles byte, halfword and word sizes, byte enables, load sign extension and misalignment detection.

## Interface
- ACK_TIMEOUT, default 15: maximum cycles in REQ without `bus_ack`. Only used when `LSU_TIMEOUT_EN` is defined.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low (0 = reset)
- lsu_valid  in  1  core requests an access; held with all fields stable while `stall`=1
- lsu_we  in  1  1 = store, 0 = load
- lsu_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- lsu_unsigned  in  1  zero-extend loads (LBU/LHU)
- lsu_addr  in  32  byte address (ALUOut)
- lsu_wdata  in  32  store data (rs2), right-aligned
- stall  out  1  freeze PC/regfile while 1
- lsu_rdata  out  32  formatted load data; valid while state=DONE
- lsu_err  out  1  one-cycle pulse: misaligned, illegal size or timeout
- bus_req  out  1  request; held until `bus_ack`
- bus_we  out  1  write strobe
- bus_addr  out  32  word-aligned address (`lsu_addr[31:2]`,2'b00)
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  responder completion, sampled only in REQ
- bus_rdata  in  32  read word, valid with `bus_ack` on loads

## Operation
- States: IDLE, REQ, DONE, ERR.
- IDLE: `lsu_valid`=1 and aligned/legal -> REQ; misaligned/illegal -> ERR; else stay.
- REQ: `bus_req`=1 with registered `bus_we/addr/be/wdata`; `bus_ack`=1 -> DONE (capture formatted load data into `lsu_rdata`); else stay.
- DONE: `stall`=0, `lsu_rdata` valid -> IDLE unconditionally (the core advances on this edge; no re-issue).
- ERR: `stall`=0, `lsu_err`=1, no bus activity -> IDLE.
- `stall` = (state==IDLE & lsu_valid) | state==REQ. It is combinational from `lsu_valid` in IDLE.
- Byte enables: byte `4'b0001<<addr[1:0]`; half `4'b0011<<{addr[1],1'b0}`; word `4'b1111`.
- Store data: byte replicated ×4; half replicated ×2; word passed through.
- Load: extract the addressed lane, then sign-extend from bit 7/15 unless `lsu_unsigned`.
- Misaligned: half with addr[0]=1; word with addr[1:0]≠0; size 11 always an error.
- `bus_ack` outside REQ is ignored. `lsu_rdata` holds its last value outside DONE. It is not updated on stores.

## Timing
- Reset values: state IDLE, `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_be`=0, `bus_wdata`=0, `lsu_rdata`=0, `lsu_err`=0. `stall` follows `lsu_valid`.
- Asserting `rst` mid-transaction drops `bus_req` immediately (asynchronous). The responder must tolerate an abandoned request.
- Zero-wait responder (ack in the first REQ cycle): 3 cycles, IDLE→REQ→DONE, `stall` high for 2 cycles.
- Each extra wait cycle of `bus_ack` adds one stall cycle.
- Error path: 2 cycles, IDLE→ERR, `stall` high for 1 cycle.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - An 8-bit counter clears on REQ entry and increments each REQ cycle without ack.
  - On reaching ACK_TIMEOUT: go to ERR, deassert `bus_req`.
  - An ack arriving in the same cycle as the limit wins (-> DONE).
- Not defined: no counter; REQ waits indefinitely.

## Structure
- `lsu_pkg`: state enum (IDLE/REQ/DONE/ERR), size encodings (SZ_B/SZ_H/SZ_W), default ACK_TIMEOUT.
- Sub-module `lsu_lane_align`: combinational. Takes size, addr[1:0], unsigned, wdata and rdata; produces be, replicated wdata, formatted rdata and misalign. The top level holds the FSM, output registers and timeout counter.

## Test plan
- Store word 0xDEADBEEF @0x100, ack after 2 wait cycles -> `bus_be`=1111, `bus_addr`=0x100, `stall` high 4 cycles, no `lsu_err`.
- Load byte @0x103, `bus_rdata`=0x80FF_FF7F:
  - signed -> `lsu_rdata`=0xFFFFFF80 in DONE.
  - unsigned -> 0x00000080.
- Store half 0x1234 @0x102 -> `bus_be`=1100, `bus_wdata`=0x12341234.
- Load word @0x101 -> ERR next cycle, `lsu_err` pulse, `bus_req` never asserted, `stall` high 1 cycle.
- Reset (`rst`=0) during REQ -> `bus_req` falls the same cycle. After release, a new load completes normally.
- `LSU_TIMEOUT_EN`, ACK_TIMEOUT=15, no ack -> ERR after 15 REQ cycles, `lsu_err`=1, `bus_req` drops. Ack on cycle 15 -> DONE instead.
